debouncer_multi: RTL
====================

Name: debouncer_multi

Overview:
- N-channel, parametrised successor to the single-button trigger debouncer; conditions front-panel buttons and mechanical switches (EN trigger, mode select, etc.) before the pulser and capture control logic.
- Each channel has its own synchroniser and per-channel counter. Both rising and falling edges are debounced symmetrically.
- Each channel emits a clean level plus single-cycle rise and fall strobes.

Parameters:
- N_CH, 4, number of independent channels (1..32)
- CNT_W, 18, counter width; must satisfy 2^CNT_W >= DEB_CYCLES
- DEB_CYCLES, 250000, consecutive stable cycles required to accept a change (10 ms at 25 MHz); minimum 2
- SYNC_STAGES, 2, synchroniser flops per channel (2..4)
- RST_VAL, {N_CH{1'b0}}, per-channel reset level of sync chain and out

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- in  in  N_CH  raw asynchronous button/switch inputs
- out  out  N_CH  debounced level
- rise  out  N_CH  1-cycle strobe, coincident with out going 0->1
- fall  out  N_CH  1-cycle strobe, coincident with out going 1->0
- busy  out  N_CH  high while the channel's counter is non-zero (a change is being qualified)

Behaviour:
- Reset (async assert, sync release on clk):
  - sync chain[i] = RST_VAL[i]; out[i] = RST_VAL[i]
  - cnt[i] = 0; rise = fall = busy = 0
  - No strobe on the first cycle after reset when in == RST_VAL.
- Synchroniser: in[i] passes through SYNC_STAGES flops; s[i] is the last stage. No logic before the first flop.
- Per channel, evaluated every clk edge:
  - s == out: cnt <= 0 (any glitch restarts qualification).
  - s != out and cnt < DEB_CYCLES-1: cnt <= cnt+1.
  - s != out and cnt == DEB_CYCLES-1: out <= s; cnt <= 0; rise <= s; fall <= ~s.
  - rise/fall are registered, high exactly one cycle, and never both high on the same channel.
- Latency: a clean input step is reflected on out at the (SYNC_STAGES + DEB_CYCLES)-th rising edge, counting the first edge that samples the new value. rise/fall assert on that same edge.
- Equivalent FSM per channel: STABLE_LO, QUAL_HI, STABLE_HI, QUAL_LO.
  - STABLE_LO -> QUAL_HI when s = 1.
  - QUAL_HI -> STABLE_LO when s = 0.
  - QUAL_HI -> STABLE_HI when terminal count is reached.
  - STABLE_HI, QUAL_LO: mirror of the above.
  - Encoding is free; the observable behaviour is what is specified.
- busy = (cnt != 0), registered with cnt.
- Boundaries:
  - Input toggling every cycle: out never changes; cnt repeatedly returns to 0.
  - Input returning to out on the terminal-count cycle: no change; cnt <= 0.
  - Counter never wraps: the terminal compare caps it at DEB_CYCLES-1.
  - Channels are fully independent; simultaneous changes on several channels each qualify on their own.
  - rst mid-qualification: immediately forces out = RST_VAL, cnt = 0, strobes low. Qualification restarts after release.
- Width rule: cnt is CNT_W bits. The compare constant is DEB_CYCLES-1 truncated to CNT_W; parameter legality is checked at elaboration with a $error if violated.

Decomposition:
- Shared package debounce_pkg:
  - DEB_10MS_25MHZ = 250000
  - DEB_SIM_DEFAULT = 8
  - channel-index localparams for the front panel (CH_EN_TRIG = 0, ...)
- Sub-module debounce_channel (one synchroniser + counter + strobe generation, scalar ports), instanced N_CH times in a generate loop. The top level is pure generate wiring.

Test Plan (N_CH = 4, DEB_CYCLES = 8, SYNC_STAGES = 2, RST_VAL = 0, CNT_W = 4):
- Clean step: in[0] 0->1 held -> out[0] rises on the 10th edge after the change; rise[0] = 1 for exactly that cycle; busy[0] high for 7 cycles before it; other channels are unaffected.
- Glitch rejection: in[1] high for 7 cycles then low -> out[1] stays 0, rise[1] never asserts, cnt returns to 0. Repeat with a 1-cycle low dip at cycle 5 of a high press -> qualification restarts; out[1] rises 8 edges after the dip ends plus sync.
- Release debounce: with out[2] = 1, drop in[2] to 0 for 8+ cycles -> out[2] falls after 10 edges; fall[2] pulses once; rise[2] stays 0.
- Bounce burst: in[3] toggles 0/1 every 3 cycles for 40 cycles, then holds 1 -> a single rise[3], 10 edges after the final hold begins; no fall[3].
- Simultaneous channels: in[3:0] = 4'b1111 on the same edge -> all out bits and all rise bits assert on the same edge.
- Reset mid-qualification: assert rst asynchronously (between edges) while cnt[0] = 5 -> out = 0, busy = 0, strobes 0 immediately. After release with in[0] still high, out[0] rises 10 edges later. Also RST_VAL = 4'b0001 with in[0] = 1 -> no rise strobe after reset.

Source files
------------

// File: rtl/debounce_pkg.sv
// Shared constants and per-channel state type for the
// front-panel button/switch debouncer.
package debounce_pkg;

  localparam int DEB_10MS_25MHZ  = 250000;
  localparam int DEB_SIM_DEFAULT = 8;

  localparam int CH_EN_TRIG  = 0;
  localparam int CH_MODE_SEL = 1;
  localparam int CH_ARM      = 2;
  localparam int CH_AUX      = 3;

  typedef enum logic [1:0] {
    STABLE_LO = 2'd0,
    QUAL_HI   = 2'd1,
    STABLE_HI = 2'd2,
    QUAL_LO   = 2'd3
  } ch_state_t;

endpackage

// File: rtl/debounce_channel.sv
// One debounce lane: synchroniser, qualification counter and
// registered level/edge outputs.
module debounce_channel
  import debounce_pkg::*;
#(
  parameter int   CNT_W       = 18,
  parameter int   DEB_CYCLES  = DEB_10MS_25MHZ,
  parameter int   SYNC_STAGES = 2,
  parameter logic RST_VAL     = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic in,
  output logic out,
  output logic rise,
  output logic fall,
  output logic busy
);

  localparam logic [CNT_W-1:0] TERM =
    CNT_W'(DEB_CYCLES - 1);
  localparam ch_state_t RST_ST =
    RST_VAL ? STABLE_HI : STABLE_LO;

  logic [SYNC_STAGES-1:0] sync;
  logic                   s;
  logic [CNT_W-1:0]       cnt;
  ch_state_t              st;

  assign s = sync[SYNC_STAGES-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync <= {SYNC_STAGES{RST_VAL}};
      st   <= RST_ST;
      cnt  <= '0;
      out  <= RST_VAL;
      rise <= 1'b0;
      fall <= 1'b0;
      busy <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], in};
      rise <= 1'b0;
      fall <= 1'b0;
      unique case (st)
        STABLE_LO: begin
          if (s) begin
            st   <= QUAL_HI;
            cnt  <= CNT_W'(1);
            busy <= 1'b1;
          end
        end
        QUAL_HI: begin
          if (!s) begin
            st   <= STABLE_LO;
            cnt  <= '0;
            busy <= 1'b0;
          end else if (cnt == TERM) begin
            st   <= STABLE_HI;
            cnt  <= '0;
            busy <= 1'b0;
            out  <= 1'b1;
            rise <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        STABLE_HI: begin
          if (!s) begin
            st   <= QUAL_LO;
            cnt  <= CNT_W'(1);
            busy <= 1'b1;
          end
        end
        QUAL_LO: begin
          if (s) begin
            st   <= STABLE_HI;
            cnt  <= '0;
            busy <= 1'b0;
          end else if (cnt == TERM) begin
            st   <= STABLE_LO;
            cnt  <= '0;
            busy <= 1'b0;
            out  <= 1'b0;
            fall <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/debouncer_multi.sv
// N-channel debouncer: independent lanes wired side by side,
// with parameter legality checked at elaboration.
module debouncer_multi
  import debounce_pkg::*;
#(
  parameter int              N_CH        = 4,
  parameter int              CNT_W       = 18,
  parameter int              DEB_CYCLES  = DEB_10MS_25MHZ,
  parameter int              SYNC_STAGES = 2,
  parameter logic [N_CH-1:0] RST_VAL     = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] in,
  output logic [N_CH-1:0] out,
  output logic [N_CH-1:0] rise,
  output logic [N_CH-1:0] fall,
  output logic [N_CH-1:0] busy
);

  localparam longint CNT_CAP = longint'(1) << CNT_W;

  if (N_CH < 1 || N_CH > 32) begin : g_bad_nch
    $error("debouncer_multi: N_CH out of range");
  end
  if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
    $error("debouncer_multi: SYNC_STAGES out of range");
  end
  if (DEB_CYCLES < 2) begin : g_bad_deb
    $error("debouncer_multi: DEB_CYCLES below 2");
  end
  if (longint'(DEB_CYCLES) > CNT_CAP) begin : g_bad_cnt
    $error("debouncer_multi: CNT_W too narrow");
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    debounce_channel #(
      .CNT_W       (CNT_W),
      .DEB_CYCLES  (DEB_CYCLES),
      .SYNC_STAGES (SYNC_STAGES),
      .RST_VAL     (RST_VAL[i])
    ) u_ch (
      .clk  (clk),
      .rst  (rst),
      .in   (in[i]),
      .out  (out[i]),
      .rise (rise[i]),
      .fall (fall[i]),
      .busy (busy[i])
    );
  end

endmodule
